// File: rtl/ddr3_burst_arbiter.sv
// rtl/ddr3_burst_arbiter.sv - round-robin burst scheduler between video FIFOs and the DDR3 user port
module ddr3_burst_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int BURST_LEN      = 64,
    parameter int FRAME_WORDS    = 1048576,
    parameter logic [DDR_ADDR_WIDTH-1:0] WR_BASE = '0,
    parameter logic [DDR_ADDR_WIDTH-1:0] RD_BASE = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      wr_frame_start,
    input  logic                      rd_frame_start,
    input  logic [ADDR_WIDTH:0]       wfifo_level,
    input  logic [DATA_WIDTH-1:0]     wfifo_rd_data,
    output logic                      wfifo_rd_en,
    input  logic [ADDR_WIDTH:0]       rfifo_level,
    output logic                      rfifo_wr_en,
    output logic [DATA_WIDTH-1:0]     rfifo_wr_data,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_wr,
    output logic [DDR_ADDR_WIDTH-1:0] cmd_addr,
    output logic [ADDR_WIDTH:0]       cmd_len,
    output logic                      wdata_valid,
    input  logic                      wdata_ready,
    output logic [DATA_WIDTH-1:0]     wdata,
    input  logic                      rdata_valid,
    input  logic [DATA_WIDTH-1:0]     rdata,
    output logic                      busy
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] BURST_L   = LW'(BURST_LEN);
    localparam logic [LW-1:0] LAST_BEAT = LW'(BURST_LEN - 1);
    localparam logic [LW-1:0] DEPTH     = LW'(2 ** ADDR_WIDTH);
    localparam logic [DDR_ADDR_WIDTH-1:0] BURST_A = DDR_ADDR_WIDTH'(BURST_LEN);
    localparam logic [DDR_ADDR_WIDTH-1:0] FRAME_W = DDR_ADDR_WIDTH'(FRAME_WORDS);

    typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;

    state_t                    state, state_n;
    logic [LW-1:0]             beat_cnt, beat_n;
    logic                      last_grant_wr, last_grant_n;
    logic [DDR_ADDR_WIDTH-1:0] wr_off, rd_off;
    logic                      wr_pend, rd_pend;
    logic                      wr_end, rd_end;
    logic                      wr_req, rd_req, pick_wr;
    logic [DDR_ADDR_WIDTH-1:0] wr_sum, rd_sum, wr_next, rd_next;
    logic                      wr_active, rd_active;

    // Free space on the read side; a level above depth would mean a broken FIFO, treat as full.
    assign wr_req  = wfifo_level >= BURST_L;
    assign rd_req  = (rfifo_level <= DEPTH) && ((DEPTH - rfifo_level) >= BURST_L);
    assign pick_wr = (wr_req && rd_req) ? !last_grant_wr : wr_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            beat_cnt      <= '0;
            last_grant_wr <= 1'b0;
        end else begin
            state         <= state_n;
            beat_cnt      <= beat_n;
            last_grant_wr <= last_grant_n;
        end
    end

    always_comb begin
        state_n      = state;
        beat_n       = beat_cnt;
        last_grant_n = last_grant_wr;
        wr_end       = 1'b0;
        rd_end       = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (wr_req || rd_req)) begin
                    state_n      = pick_wr ? WR_CMD : RD_CMD;
                    last_grant_n = pick_wr;
                end
            end
            WR_CMD: begin
                if (cmd_ready) begin
                    state_n = WR_DATA;
                    beat_n  = '0;
                end
            end
            RD_CMD: begin
                if (cmd_ready) begin
                    state_n = RD_DATA;
                    beat_n  = '0;
                end
            end
            WR_DATA: begin
                if (wdata_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_n = IDLE;
                        wr_end  = 1'b1;
                    end else begin
                        beat_n = beat_cnt + 1'b1;
                    end
                end
            end
            RD_DATA: begin
                if (rdata_valid) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_n = IDLE;
                        rd_end  = 1'b1;
                    end else begin
                        beat_n = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign wr_active = (state == WR_CMD) || (state == WR_DATA);
    assign rd_active = (state == RD_CMD) || (state == RD_DATA);
    assign wr_sum    = wr_off + BURST_A;
    assign rd_sum    = rd_off + BURST_A;
    assign wr_next   = (wr_sum == FRAME_W) ? '0 : wr_sum;
    assign rd_next   = (rd_sum == FRAME_W) ? '0 : rd_sum;

    // A frame restart during a burst is deferred so the burst in flight keeps its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_off  <= '0;
            wr_pend <= 1'b0;
        end else if (wr_end) begin
            wr_off  <= (wr_pend || wr_frame_start) ? '0 : wr_next;
            wr_pend <= 1'b0;
        end else if (wr_frame_start) begin
            if (wr_active) begin
                wr_pend <= 1'b1;
            end else begin
                wr_off <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_off  <= '0;
            rd_pend <= 1'b0;
        end else if (rd_end) begin
            rd_off  <= (rd_pend || rd_frame_start) ? '0 : rd_next;
            rd_pend <= 1'b0;
        end else if (rd_frame_start) begin
            if (rd_active) begin
                rd_pend <= 1'b1;
            end else begin
                rd_off <= '0;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign cmd_valid     = (state == WR_CMD) || (state == RD_CMD);
    assign cmd_wr        = (state == WR_CMD);
    assign cmd_addr      = (state == WR_CMD) ? (WR_BASE + wr_off) :
                           (state == RD_CMD) ? (RD_BASE + rd_off) : '0;
    assign cmd_len       = BURST_L;
    assign wdata_valid   = (state == WR_DATA);
    assign wdata         = (state == WR_DATA) ? wfifo_rd_data : '0;
    assign wfifo_rd_en   = (state == WR_DATA) && wdata_ready;
    assign rfifo_wr_en   = (state == RD_DATA) && rdata_valid;
    assign rfifo_wr_data = (state == RD_DATA) ? rdata : '0;

endmodule

// File: tb/tb_ddr3_burst_arbiter.sv
// tb/tb_ddr3_burst_arbiter.sv - directed self-checking bench for ddr3_burst_arbiter
module tb_ddr3_burst_arbiter;

    localparam logic [27:0] WR_BASE = 28'h100;
    localparam logic [27:0] RD_BASE = 28'h4000;

    logic        clk = 1'b0;
    logic        rst_n, enable, wr_frame_start, rd_frame_start;
    logic [10:0] wfifo_level, rfifo_level, cmd_len;
    logic [31:0] wfifo_rd_data, rfifo_wr_data, wdata, rdata;
    logic        wfifo_rd_en, rfifo_wr_en, cmd_valid, cmd_ready, cmd_wr;
    logic [27:0] cmd_addr;
    logic        wdata_valid, wdata_ready, rdata_valid, busy;

    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    int          push_cnt = 0;
    logic [31:0] fifo_head = 32'h0000_1000;

    always #5 clk = ~clk;

    ddr3_burst_arbiter #(
        .ADDR_WIDTH(10), .DATA_WIDTH(32), .DDR_ADDR_WIDTH(28), .BURST_LEN(64),
        .FRAME_WORDS(128), .WR_BASE(WR_BASE), .RD_BASE(RD_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
        .wfifo_level(wfifo_level), .wfifo_rd_data(wfifo_rd_data), .wfifo_rd_en(wfifo_rd_en),
        .rfifo_level(rfifo_level), .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy)
    );

    // Show-ahead FIFO model and push counter
    assign wfifo_rd_data = fifo_head;
    assign rdata = {16'hD00D, push_cnt[15:0]};
    always @(posedge clk) begin
        if (wfifo_rd_en) begin
            fifo_head <= fifo_head + 32'd1;
            pop_cnt   <= pop_cnt + 1;
        end
        if (rfifo_wr_en) push_cnt <= push_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cmd(input string tag, input logic exp_wr, input logic [27:0] exp_addr);
        int n = 0;
        while (!cmd_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_seen"}, 32'(cmd_valid), 32'd1);
        check({tag, "_wr"}, 32'(cmd_wr), 32'(exp_wr));
        check({tag, "_addr"}, 32'(cmd_addr), 32'(exp_addr));
        check({tag, "_len"}, 32'(cmd_len), 32'd64);
        @(negedge clk);
    endtask

    task automatic wr_burst(input bit toggle, input int fs_beat);
        int n = 0;
        int p0 = pop_cnt;
        int q0 = push_cnt;
        bit fs_done = 0;
        while (busy && n < 400) begin
            check("wr_rd_en_mirror", 32'(wfifo_rd_en), 32'(wdata_ready));
            check("wr_wdata_head", wdata, fifo_head);
            wr_frame_start = 1'b0;
            if (!fs_done && fs_beat >= 0 && pop_cnt - p0 == fs_beat) begin
                wr_frame_start = 1'b1;
                fs_done = 1;
            end
            if (toggle) wdata_ready = ~wdata_ready;
            @(negedge clk);
            n++;
        end
        wr_frame_start = 1'b0;
        wdata_ready = 1'b1;
        check("wr_burst_end", 32'(busy), 32'd0);
        check("wr_pop_count", 32'(pop_cnt - p0), 32'd64);
        check("wr_no_push", 32'(push_cnt - q0), 32'd0);
    endtask

    task automatic rd_burst();
        int n = 0;
        int q0 = push_cnt;
        while (busy && n < 400) begin
            check("rd_passthrough", rfifo_wr_data, rdata);
            @(negedge clk);
            n++;
        end
        check("rd_burst_end", 32'(busy), 32'd0);
        check("rd_push_count", 32'(push_cnt - q0), 32'd64);
    endtask

    initial begin
        int n;
        int q0;
        rst_n = 1'b0; enable = 1'b0; wr_frame_start = 1'b0; rd_frame_start = 1'b0;
        wfifo_level = '0; rfifo_level = 11'd1024; cmd_ready = 1'b0;
        wdata_ready = 1'b0; rdata_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_rfifo_wr_en", 32'(rfifo_wr_en), 32'd0);
        check("rst_wdata_valid", 32'(wdata_valid), 32'd0);

        // Single write burst, read side full
        rst_n = 1'b1; enable = 1'b1; cmd_ready = 1'b1; wdata_ready = 1'b1;
        wfifo_level = 11'd64;
        wait_cmd("t1", 1'b1, WR_BASE);
        wfifo_level = '0;
        wr_burst(0, -1);
        repeat (5) @(negedge clk);
        check("t1_no_regrant", 32'(cmd_valid), 32'd0);

        // Both pending: alternate starting with read, write offset wraps at 128
        wfifo_level = 11'd64; rfifo_level = '0;
        wait_cmd("t2_rd0", 1'b0, RD_BASE);
        rd_burst();
        wait_cmd("t2_wr64", 1'b1, WR_BASE + 28'd64);
        wr_burst(0, -1);
        wait_cmd("t2_rd64", 1'b0, RD_BASE + 28'd64);
        rd_burst();
        wait_cmd("t2_wr_wrap", 1'b1, WR_BASE);
        rfifo_level = 11'd1024;
        wr_burst(1, -1);

        // Frame restart mid-burst takes effect on the next burst
        wait_cmd("t5_wr64", 1'b1, WR_BASE + 28'd64);
        wr_burst(0, 10);
        wait_cmd("t5_after_fs", 1'b1, WR_BASE);
        enable = 1'b0;
        wr_burst(0, -1);
        repeat (10) @(negedge clk);
        check("t7_disabled_cmd", 32'(cmd_valid), 32'd0);
        check("t7_disabled_busy", 32'(busy), 32'd0);

        // Frame restart while idle clears the offset at once
        wr_frame_start = 1'b1;
        @(negedge clk);
        wr_frame_start = 1'b0;
        enable = 1'b1;
        wait_cmd("t6_idle_fs", 1'b1, WR_BASE);
        wfifo_level = '0;
        wr_burst(0, -1);

        // Reset during read beat 30 abandons the burst and clears offsets
        rfifo_level = '0;
        wait_cmd("t8_rd0", 1'b0, RD_BASE);
        rd_burst();
        wait_cmd("t8_rd64", 1'b0, RD_BASE + 28'd64);
        q0 = push_cnt;
        n = 0;
        while (push_cnt - q0 < 30 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t8_beat30_reached", 32'(push_cnt - q0), 32'd30);
        rst_n = 1'b0;
        #1;
        check("t8_rst_busy", 32'(busy), 32'd0);
        check("t8_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("t8_rst_rfifo_wr_en", 32'(rfifo_wr_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wfifo_level = 11'd64;
        wait_cmd("t8_wr_after_rst", 1'b1, WR_BASE);
        wr_burst(0, -1);
        wait_cmd("t8_rd_after_rst", 1'b0, RD_BASE);
        rd_burst();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
